// File: rtl/seg7_pkg.sv
// Seven-segment definitions shared by the scan decoder and the segment encoder.
// Codes are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam logic [6:0] SegBlank = 7'h7F;

  localparam logic [6:0] SegCodes [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StDone   = 2'd2
  } state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    return SegCodes[nibble];
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Inverse segment lookup: maps an active-low 7-bit pattern back to its hex nibble.
// Patterns outside the code table report legal = 0; the all-off pattern reports blank.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SegCodes[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
    blank = (seg == SegBlank);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed seven-segment display bus and recovers the digit values once each
// digit's pattern has been stable for STABLE_CYCLES synchronized samples.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [6:0]              iSEG,
  input  logic [NUM_DIGITS-1:0]   iDIG_N,
  output logic [4*NUM_DIGITS-1:0] oVALUE,
  output logic [NUM_DIGITS-1:0]   oDIG_VALID,
  output logic [NUM_DIGITS-1:0]   oDIG_ERR,
  output logic                    oUPD
);

  localparam int unsigned SampW  = NUM_DIGITS + 7;
  localparam logic [7:0]  CntMax = 8'(STABLE_CYCLES);

  logic [SampW-1:0]        sync_meta;
  logic [SampW-1:0]        samp;
  logic [SampW-1:0]        samp_last;
  logic [NUM_DIGITS-1:0]   dig_act;
  logic                    one_active;
  logic                    changed;

  state_e                  state;
  logic [7:0]              cnt;

  logic [3:0]              dec_nibble;
  logic                    dec_legal;
  logic                    dec_blank;

  logic [4*NUM_DIGITS-1:0] value_cap;
  logic [NUM_DIGITS-1:0]   valid_cap;
  logic [NUM_DIGITS-1:0]   err_cap;
  logic                    cap_upd;

  assign dig_act    = ~samp[SampW-1:7];
  assign one_active = $onehot(dig_act);
  assign changed    = (samp != samp_last);

  seg7_pattern_dec u_pattern_dec (
    .seg    (samp[6:0]),
    .nibble (dec_nibble),
    .legal  (dec_legal),
    .blank  (dec_blank)
  );

  // Register-file contents as they would look after capturing the current sample.
  always_comb begin
    value_cap = oVALUE;
    valid_cap = oDIG_VALID;
    err_cap   = oDIG_ERR;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_act[k]) begin
        if (dec_legal) begin
          value_cap[4*k +: 4] = dec_nibble;
          valid_cap[k]        = 1'b1;
          err_cap[k]          = 1'b0;
        end else begin
          valid_cap[k] = 1'b0;
          err_cap[k]   = ~dec_blank;
        end
      end
    end
    cap_upd = (value_cap != oVALUE) || (valid_cap != oDIG_VALID);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_meta  <= '1;
      samp       <= '1;
      samp_last  <= '1;
      state      <= StIdle;
      cnt        <= '0;
      oVALUE     <= '0;
      oDIG_VALID <= '0;
      oDIG_ERR   <= '0;
      oUPD       <= 1'b0;
    end else begin
      sync_meta <= {iDIG_N, iSEG};
      samp      <= sync_meta;
      samp_last <= samp;
      oUPD      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (changed && one_active) begin
            state <= StSettle;
            cnt   <= 8'd1;
          end
        end
        StSettle, StDone: begin
          if (changed) begin
            if (one_active) begin
              state <= StSettle;
              cnt   <= 8'd1;
            end else begin
              state <= StIdle;
              cnt   <= '0;
            end
          end else if (state == StSettle) begin
            if (cnt == CntMax) begin
              oVALUE     <= value_cap;
              oDIG_VALID <= valid_cap;
              oDIG_ERR   <= err_cap;
              oUPD       <= cap_upd;
              state      <= StDone;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          // StDone with an unchanged sample holds; cnt stays saturated.
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized scoreboard bench for seg7_scan_decoder: stimulus runs feed a behavioural model
// that queues expected updates; an independent monitor checks every oUPD pulse.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      seg;
  logic [ND-1:0]   dig_n;
  logic [4*ND-1:0] value;
  logic [ND-1:0]   dig_valid;
  logic [ND-1:0]   dig_err;
  logic            upd;

  seg7_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iSEG       (seg),
    .iDIG_N     (dig_n),
    .oVALUE     (value),
    .oDIG_VALID (dig_valid),
    .oDIG_ERR   (dig_err),
    .oUPD       (upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   valid;
    logic [ND-1:0]   err;
  } exp_t;

  exp_t q[$];

  int n_cmp   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int upd_cnt = 0;

  logic [6:0]      codes [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [4*ND-1:0] m_value = '0;
  logic [ND-1:0]   m_valid = '0;
  logic [ND-1:0]   m_err   = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  // A run of one input held for len cycles is captured iff exactly one digit is enabled and
  // the input persists for at least SC+1 cycles; the capture is visible SC+3 cycles after
  // the cycle in which the input was applied.
  task automatic model_run(input logic [6:0] s, input logic [ND-1:0] d, input int start,
                           input int len);
    int k;
    int nz;
    int code;
    exp_t e;
    k  = 0;
    nz = 0;
    for (int i = 0; i < ND; i++) begin
      if (!d[i]) begin
        nz++;
        k = i;
      end
    end
    if (nz != 1 || len < SC + 1) return;
    code    = decode(s);
    e.cyc   = start + SC + 3;
    e.value = m_value;
    e.valid = m_valid;
    e.err   = m_err;
    if (code >= 0) begin
      e.value[4*k +: 4] = 4'(code);
      e.valid[k]        = 1'b1;
      e.err[k]          = 1'b0;
    end else begin
      e.valid[k] = 1'b0;
      e.err[k]   = (s != 7'h7F);
    end
    if (e.value != m_value || e.valid != m_valid) q.push_back(e);
    m_value = e.value;
    m_valid = e.valid;
    m_err   = e.err;
  endtask

  task automatic drive(input logic [6:0] s, input logic [ND-1:0] d, input int len);
    seg   = s;
    dig_n = d;
    model_run(s, d, cyc, len);
    repeat (len) @(posedge clk);
    #1;
  endtask

  // Monitor: every update pulse must match the oldest queued expectation, on time.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (upd) begin
        upd_cnt++;
        if (q.size() == 0) begin
          check("upd_unexpected", 32'(upd), 32'd0);
        end else begin
          e = q.pop_front();
          check("upd_cycle", 32'(cyc), 32'(e.cyc));
          check("upd_value", 32'(value), 32'(e.value));
          check("upd_valid", 32'(dig_valid), 32'(e.valid));
          check("upd_err", 32'(dig_err), 32'(e.err));
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        check("upd_missing", 32'(upd), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]    s;
    logic [ND-1:0] d;
    logic [6:0]    last_s;
    logic [ND-1:0] last_d;
    logic [31:0]   snap;
    int            base;
    int            r;

    rst_n = 1'b0;
    seg   = 7'h7F;
    dig_n = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", 32'(value), 32'd0);
    check("reset_valid", 32'(dig_valid), 32'd0);
    check("reset_err", 32'(dig_err), 32'd0);
    check("reset_upd", 32'(upd), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single digit, held well past the window.
    base = upd_cnt;
    drive(7'h24, 4'b1110, 20);
    check("t30_nibble0", 32'(value[3:0]), 32'd2);
    check("t30_valid", 32'(dig_valid), 32'b0001);
    check("t30_upd_count", 32'(upd_cnt - base), 32'd1);

    // Scan all four digits twice; the second pass repeats values and must stay quiet.
    base = upd_cnt;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < ND; k++) drive(codes[k], ~(4'b0001 << k), 12);
    end
    check("t31_value", 32'(value), 32'h3210);
    check("t31_valid", 32'(dig_valid), 32'hF);
    check("t31_upd_count", 32'(upd_cnt - base), 32'd4);

    // Short-lived pattern must be ignored.
    drive(7'h12, 4'b1101, 5);
    drive(7'h19, 4'b1101, 12);
    check("t32_nibble1", 32'(value[7:4]), 32'd4);

    // Illegal pattern, then a legal one on the same digit.
    drive(7'h55, 4'b1011, 12);
    check("t33_err2", 32'(dig_err[2]), 32'd1);
    check("t33_valid2", 32'(dig_valid[2]), 32'd0);
    drive(7'h0E, 4'b1011, 12);
    check("t33_err2_clr", 32'(dig_err[2]), 32'd0);
    check("t33_nibble2", 32'(value[11:8]), 32'hF);

    // Two digits enabled at once: nothing may change.
    base = upd_cnt;
    snap = {dig_err, dig_valid, value[7:0]};
    drive(7'h30, 4'b1100, 20);
    check("t34_state", {dig_err, dig_valid, value[7:0]}, snap);
    check("t34_upd_count", 32'(upd_cnt - base), 32'd0);
    check("t34_value_hi", 32'(value[15:8]), 32'(m_value[15:8]));
    last_s = 7'h30;
    last_d = 4'b1100;

    // Random runs with lengths straddling the capture threshold.
    for (int i = 0; i < 150; i++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 6) d = ~(4'b0001 << $urandom_range(0, ND - 1));
        else if (r < 7) d = '1;
        else d = 4'($urandom);
        r = $urandom_range(0, 9);
        if (r < 7) s = codes[$urandom_range(0, 15)];
        else if (r < 8) s = 7'h7F;
        else s = 7'($urandom);
      end while ((s == last_s && d == last_d) || (s == 7'h7F && d == '1));
      drive(s, d, $urandom_range(1, SC + 4));
      last_s = s;
      last_d = d;
    end
    drive(7'h7F, '1, SC + 5);
    check("rand_value", 32'(value), 32'(m_value));
    check("rand_valid", 32'(dig_valid), 32'(m_valid));
    check("rand_err", 32'(dig_err), 32'(m_err));

    // Reset in the middle of a settle window (counter at 5).
    seg   = 7'h79;
    dig_n = 4'b1110;
    repeat (SC - 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t35_value", 32'(value), 32'd0);
    check("t35_valid", 32'(dig_valid), 32'd0);
    check("t35_err", 32'(dig_err), 32'd0);
    check("t35_upd", 32'(upd), 32'd0);
    m_value = '0;
    m_valid = '0;
    m_err   = '0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_run(7'h79, 4'b1110, cyc, SC + 6);
    repeat (SC + 6) @(posedge clk);
    #1;
    check("t35_nibble0", 32'(value[3:0]), 32'd1);
    check("t35_valid_after", 32'(dig_valid), 32'b0001);
    drive(7'h7F, '1, SC + 5);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4: number of multiplexed digit positions monitored.
REQ-002 SHALL provide parameter STABLE_CYCLES, default 8, legal range 2..255: consecutive identical samples required before a capture.
REQ-003 SHALL provide port iCLK  input  1: single clock; all state on rising edge.
REQ-004 SHALL provide port iRST_N  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL provide port iSEG  input  7: active-low segment lines, bit0=a … bit6=g (0 = segment lit).
REQ-006 SHALL provide port iDIG_N  input  NUM_DIGITS: active-low digit enables, bit k = digit k.
REQ-007 SHALL provide port oVALUE  output  4*NUM_DIGITS: decoded nibbles, digit k at bits [4k+3:4k].
REQ-008 SHALL provide port oDIG_VALID  output  NUM_DIGITS: bit k = digit k holds a decoded value.
REQ-009 SHALL provide port oDIG_ERR  output  NUM_DIGITS: bit k = last capture of digit k was an illegal pattern.
REQ-010 SHALL provide port oUPD  output  1: one-cycle pulse when any digit's value or valid bit changes.

Function
REQ-011 SHALL pass {iDIG_N, iSEG} through a 2-flop synchronizer; all decisions use the synchronized sample S.
REQ-012 SHALL run FSM states IDLE, SETTLE, DONE; an 8-bit stability counter CNT counts consecutive cycles with S unchanged.
REQ-013 SHALL go to IDLE whenever zero or more than one iDIG_N bit is low in S; no capture from IDLE.
REQ-014 SHALL go to SETTLE with CNT=1 when S changes and exactly one digit is active; CNT increments each unchanged cycle.
REQ-015 SHALL capture when CNT reaches STABLE_CYCLES, then enter DONE; DONE holds (no recapture) until S changes.
REQ-016 SHALL capture at the rising edge STABLE_CYCLES+2 cycles after the edge at which the new input first appears.
REQ-017 SHALL decode 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x18→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
REQ-018 SHALL on legal capture write the nibble to digit k, set oDIG_VALID[k], clear oDIG_ERR[k].
REQ-019 SHALL on blank pattern 0x7F clear oDIG_VALID[k], clear oDIG_ERR[k], keep nibble unchanged.
REQ-020 SHALL on any other pattern set oDIG_ERR[k], clear oDIG_VALID[k], keep nibble unchanged.
REQ-021 SHALL pulse oUPD in the cycle after a capture only if oDIG_VALID[k] or the nibble of digit k changed; a re-capture of an identical value SHALL NOT pulse.
REQ-022 SHALL ignore a change of S that reverts before STABLE_CYCLES (glitch): CNT restarts, no capture.
REQ-023 SHALL saturate CNT at STABLE_CYCLES; no wrap-around while in DONE.

Reset
REQ-024 SHALL on iRST_N low immediately clear synchronizer flops to all-ones (idle, no digit active), FSM to IDLE, CNT to 0.
REQ-025 SHALL on reset drive oVALUE=0, oDIG_VALID=0, oDIG_ERR=0, oUPD=0; reset mid-SETTLE discards the pending capture.
REQ-026 SHALL after reset release require a full STABLE_CYCLES+2 window before the first capture.

Structure
REQ-027 SHALL place the 16 segment code constants, blank code 0x7F and FSM state encodings in shared package seg7_pkg, also usable by the existing segment encoder.
REQ-028 SHALL implement the inverse lookup as combinational sub-module seg7_pattern_dec (7-bit in, 4-bit nibble, 1-bit legal, 1-bit blank).
REQ-029 SHALL keep FSM, counter, synchronizer and digit register file in the top module.

Verification
REQ-030 SHALL check: iDIG_N=4'b1110, iSEG=0x24 held 20 cycles -> oVALUE[3:0]=2, oDIG_VALID=0001, single oUPD at cycle STABLE_CYCLES+3.
REQ-031 SHALL check: scan digits 0..3 with 0x40,0x79,0x24,0x30, 12 cycles each, repeated twice -> oVALUE=16'h3210, oUPD exactly 4 pulses.
REQ-032 SHALL check: digit 1 shows 0x12 for 5 cycles then 0x19 for 12 -> only 4 captured, oVALUE[7:4]=4.
REQ-033 SHALL check: digit 2 shows 0x55 12 cycles -> oDIG_ERR[2]=1, oDIG_VALID[2]=0; then 0x0E -> err cleared, nibble F.
REQ-034 SHALL check: iDIG_N=4'b1100 any segments 20 cycles -> no state change, no oUPD.
REQ-035 SHALL check: iRST_N low at CNT=5 of a capture -> all outputs 0, no capture until full window after release.
